wb_trace_buf: RTL and testbench
===============================

// Module: wb_trace_buf
// PURPOSE
//  Synthesizable retirement-trace capture for the diad core; sits downstream of the WB stage.
//  Samples each retired instruction (pc, instr, result, tgt_gp) into a ring buffer.
//  Uses logic-analyzer triggering: arm, trigger on PC match, then keep POST_CNT more entries.
//  Drained afterwards over a valid/ready port by a debug host; replaces $display tracing on silicon.
// PARAMETERS
//  PC_W     24  width of retired PC
//  INSTR_W  24  width of retired instruction word
//  DATA_W   24  width of WB result
//  DEPTH    16  ring entries, power of two, >=4
//  POST_CNT 8   entries captured after (and including) the trigger entry, 1..DEPTH
// PORTS
//  iw_clk        in   1        clock, all state on rising edge
//  iw_rst        in   1        reset, asynchronous, active-low
//  iw_wb_valid   in   1        an instruction retires this cycle
//  iw_wb_pc      in   PC_W     retired PC
//  iw_wb_instr   in   INSTR_W  retired instruction
//  iw_wb_result  in   DATA_W   WB result
//  iw_wb_tgt_gp  in   4        GP target index (4'hf = none)
//  iw_arm        in   1        pulse: flush buffer, enter ARMED
//  iw_trig_pc    in   PC_W     trigger address
//  iw_rd_ready   in   1        host accepts the current read entry
//  ow_state      out  2        current FSM state
//  ow_count      out  log2(DEPTH)+1  entries held
//  ow_rd_valid   out  1        read entry present (DONE and count>0)
//  ow_rd_pc      out  PC_W     oldest entry fields, valid while ow_rd_valid=1
//  ow_rd_instr   out  INSTR_W
//  ow_rd_result  out  DATA_W
//  ow_rd_tgt_gp  out  4
//  ow_rd_ts      out  32       timestamp, only with TRACE_TS_EN
// BEHAVIOUR
//  Reset (iw_rst=0, async): state=IDLE, wr_ptr=rd_ptr=0, count=0, post=0, ts=0;
//   all ow_rd_* = 0; ow_rd_valid=0.
//  FSM: IDLE -arm-> ARMED -trigger-> POST -post done-> DONE -arm-> ARMED.
//   Encodings: IDLE=0, ARMED=1, POST=2, DONE=3.
//  arm: in any state, next cycle state=ARMED, ptrs/count=0, post=0.
//   arm beats a same-cycle capture or read.
//  ARMED: each iw_wb_valid writes entry at wr_ptr, wr_ptr++ mod DEPTH.
//   count saturates at DEPTH; when full, rd_ptr++ as well, so the oldest entry is overwritten.
//  trigger: ARMED & iw_wb_valid & iw_wb_pc==iw_trig_pc.
//   The triggering entry is written; post=1; state=POST.
//   If POST_CNT==1, go straight to DONE.
//  POST: writes as in ARMED; post++ per write.
//   On the write making post==POST_CNT, next state=DONE.
//   PC matches in POST are ignored (no retrigger).
//  DONE: no capture (iw_wb_valid ignored).
//   ow_rd_valid=(count!=0); ow_rd_* = entry[rd_ptr], driven combinationally from the RAM read port.
//   Handshake ow_rd_valid & iw_rd_ready: rd_ptr++ mod DEPTH, count--, data advances next cycle.
//   ow_rd_* must hold stable while valid & !ready.
//   count==0 in DONE: ow_rd_valid=0, state stays DONE.
//  IDLE: no capture, no reads, ow_rd_valid=0.
//  Pointers wrap modulo DEPTH; count range 0..DEPTH inclusive.
//  Resetting mid-capture or mid-drain discards all contents.
//  Latency: retire at edge N is readable (once DONE) from edge N+1.
// CONFIGURATION
//  TRACE_TS_EN defined: 32-bit free-running cycle counter ts, cleared by reset only, wraps at 2^32.
//   Each entry stores ts at write; ow_rd_ts is present.
//  TRACE_TS_EN undefined: no counter, no ts field in RAM, no ow_rd_ts port.
// STRUCTURE
//  src/trace.vh: state encodings TRACE_IDLE/ARMED/POST/DONE;
//   entry field offsets/width macros (TRACE_ENTRY_W, with and without ts).
//  Sub-module trace_ram: DEPTH x TRACE_ENTRY_W, 1 sync write port, 1 async read port.
//   FSM and pointers live in wb_trace_buf.
// TESTING
//  1 Reset mid-POST (iw_rst low 1 cycle) -> state=0, count=0, ow_rd_valid=0; no entry readable.
//  2 DEPTH=16, POST_CNT=8: arm, retire pc 0..29, trig_pc=20.
//    Expect DONE after pc 27; count=16; drain reads pc 12..27 in order; ow_rd_valid low after 16th.
//  3 Trigger on the first retire after arm (pc=5), POST_CNT=8, pcs 5..12 -> count=8, reads 5..12.
//  4 Drain with iw_rd_ready toggling 1,0,0,1 -> ow_rd_pc holds while not ready; no entry skipped or duplicated.
//  5 arm asserted in DONE with count=3 and a same-cycle read -> state=ARMED, count=0, read not counted.
//  6 TRACE_TS_EN, retires 3 cycles apart -> consecutive ow_rd_ts differ by exactly 3; build without macro also compiles and passes 2.

Source files
------------

// File: rtl/wb_trace_buf_pkg.sv
// Shared types and sizing helpers for the wb_trace_buf retirement-trace capture block.
// The TRACE_TS_EN macro adds a 32-bit timestamp field to every stored entry.
package wb_trace_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    localparam int GP_W = 4;
    localparam int TS_W = 32;

    // Stored entry layout, LSB first: tgt_gp, result, instr, pc[, ts].
    function automatic int entry_width(input int pc_w, input int instr_w, input int data_w);
`ifdef TRACE_TS_EN
        return pc_w + instr_w + data_w + GP_W + TS_W;
`else
        return pc_w + instr_w + data_w + GP_W;
`endif
    endfunction

endpackage

// File: rtl/wb_trace_buf_ram.sv
// Trace storage: DEPTH x W array with one synchronous write port and one asynchronous read port.
// Contents are intentionally not reset; validity is tracked by the pointers in wb_trace_buf.
module wb_trace_buf_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 76
) (
    input  logic          iw_clk,
    input  logic          iw_we,
    input  logic [AW-1:0] iw_waddr,
    input  logic [W-1:0]  iw_wdata,
    input  logic [AW-1:0] iw_raddr,
    output logic [W-1:0]  ow_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    // Capture one entry per enabled write.
    always_ff @(posedge iw_clk) begin
        if (iw_we) begin
            r_mem[iw_waddr] <= iw_wdata;
        end
    end

    assign ow_rdata = r_mem[iw_raddr];

endmodule

// File: rtl/wb_trace_buf.sv
// Retirement-trace ring buffer with arm / PC-trigger / post-capture and a valid/ready drain port.
// Define TRACE_TS_EN to store a free-running 32-bit cycle timestamp with each entry (adds ow_rd_ts).
module wb_trace_buf
    import wb_trace_buf_pkg::*;
#(
    parameter int PC_W     = 24,
    parameter int INSTR_W  = 24,
    parameter int DATA_W   = 24,
    parameter int DEPTH    = 16,
    parameter int POST_CNT = 8
) (
    input  logic                       iw_clk,
    input  logic                       iw_rst,
    input  logic                       iw_wb_valid,
    input  logic [PC_W-1:0]            iw_wb_pc,
    input  logic [INSTR_W-1:0]         iw_wb_instr,
    input  logic [DATA_W-1:0]          iw_wb_result,
    input  logic [GP_W-1:0]            iw_wb_tgt_gp,
    input  logic                       iw_arm,
    input  logic [PC_W-1:0]            iw_trig_pc,
    input  logic                       iw_rd_ready,
    output logic [1:0]                 ow_state,
    output logic [$clog2(DEPTH):0]     ow_count,
    output logic                       ow_rd_valid,
    output logic [PC_W-1:0]            ow_rd_pc,
    output logic [INSTR_W-1:0]         ow_rd_instr,
    output logic [DATA_W-1:0]          ow_rd_result,
    output logic [GP_W-1:0]            ow_rd_tgt_gp
`ifdef TRACE_TS_EN
    ,
    output logic [TS_W-1:0]            ow_rd_ts
`endif
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int EW      = entry_width(PC_W, INSTR_W, DATA_W);
    localparam int OFF_RES = GP_W;
    localparam int OFF_INS = OFF_RES + DATA_W;
    localparam int OFF_PC  = OFF_INS + INSTR_W;

    localparam logic [AW-1:0] PTR_INC = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_INC = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] POST_C  = CW'(POST_CNT);

    trace_state_e    r_state;
    trace_state_e    w_state_nxt;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   w_wr_ptr_nxt;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   w_rd_ptr_nxt;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic [CW-1:0]   r_post;
    logic [CW-1:0]   w_post_nxt;
    logic            w_we;
    logic            w_rd_valid;
    logic [EW-1:0]   w_wdata;
    logic [EW-1:0]   w_rdata;

`ifdef TRACE_TS_EN
    logic [TS_W-1:0] r_ts;

    // Free-running cycle counter; only reset clears it, arm does not.
    always_ff @(posedge iw_clk or negedge iw_rst) begin
        if (!iw_rst) begin
            r_ts <= 32'd0;
        end else begin
            r_ts <= r_ts + 32'd1;
        end
    end
`endif

    // Pack the retiring instruction into the RAM entry layout.
    always_comb begin
        w_wdata                       = '0;
        w_wdata[GP_W-1:0]             = iw_wb_tgt_gp;
        w_wdata[OFF_RES +: DATA_W]    = iw_wb_result;
        w_wdata[OFF_INS +: INSTR_W]   = iw_wb_instr;
        w_wdata[OFF_PC +: PC_W]       = iw_wb_pc;
`ifdef TRACE_TS_EN
        w_wdata[OFF_PC + PC_W +: TS_W] = r_ts;
`endif
    end

    wb_trace_buf_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (EW)
    ) u_ram (
        .iw_clk   (iw_clk),
        .iw_we    (w_we),
        .iw_waddr (r_wr_ptr),
        .iw_wdata (w_wdata),
        .iw_raddr (r_rd_ptr),
        .ow_rdata (w_rdata)
    );

    assign w_rd_valid = (r_state == ST_DONE) && (r_count != '0);

    // Next-state, pointer and counter logic; arm overrides any capture or read in the same cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        w_post_nxt   = r_post;
        w_we         = 1'b0;
        if (iw_arm) begin
            w_state_nxt  = ST_ARMED;
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_count_nxt  = '0;
            w_post_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_ARMED: begin
                    w_we = iw_wb_valid;
                    if (iw_wb_valid && (iw_wb_pc == iw_trig_pc)) begin
                        w_post_nxt  = CNT_INC;
                        w_state_nxt = (POST_CNT == 1) ? ST_DONE : ST_POST;
                    end else begin
                        w_post_nxt  = r_post;
                    end
                end
                ST_POST: begin
                    w_we = iw_wb_valid;
                    if (iw_wb_valid) begin
                        w_post_nxt = r_post + CNT_INC;
                        if ((r_post + CNT_INC) == POST_C) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_POST;
                        end
                    end else begin
                        w_post_nxt = r_post;
                    end
                end
                ST_DONE: begin
                    if (w_rd_valid && iw_rd_ready) begin
                        w_rd_ptr_nxt = r_rd_ptr + PTR_INC;
                        w_count_nxt  = r_count - CNT_INC;
                    end else begin
                        w_count_nxt  = r_count;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
            // A full ring drops its oldest entry so the newest retire always lands.
            if (w_we) begin
                w_wr_ptr_nxt = r_wr_ptr + PTR_INC;
                if (r_count == DEPTH_C) begin
                    w_rd_ptr_nxt = r_rd_ptr + PTR_INC;
                end else begin
                    w_count_nxt  = r_count + CNT_INC;
                end
            end else begin
                w_wr_ptr_nxt = r_wr_ptr;
            end
        end
    end

    // State, pointer and counter registers.
    always_ff @(posedge iw_clk or negedge iw_rst) begin
        if (!iw_rst) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_post   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_post   <= w_post_nxt;
        end
    end

    // Read fields are forced to zero whenever no entry is presented.
    always_comb begin
        if (w_rd_valid) begin
            ow_rd_pc     = w_rdata[OFF_PC +: PC_W];
            ow_rd_instr  = w_rdata[OFF_INS +: INSTR_W];
            ow_rd_result = w_rdata[OFF_RES +: DATA_W];
            ow_rd_tgt_gp = w_rdata[GP_W-1:0];
`ifdef TRACE_TS_EN
            ow_rd_ts     = w_rdata[OFF_PC + PC_W +: TS_W];
`endif
        end else begin
            ow_rd_pc     = '0;
            ow_rd_instr  = '0;
            ow_rd_result = '0;
            ow_rd_tgt_gp = '0;
`ifdef TRACE_TS_EN
            ow_rd_ts     = '0;
`endif
        end
    end

    assign ow_state    = r_state;
    assign ow_count    = r_count;
    assign ow_rd_valid = w_rd_valid;

endmodule

// File: tb/tb_wb_trace_buf.sv
// Self-checking bench for wb_trace_buf: vector table, directed corner sequences and a
// queue-based reference model driven by random stimulus. Honors TRACE_TS_EN when defined.
module tb_wb_trace_buf;

    localparam int DEPTH    = 16;
    localparam int POST_CNT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic [23:0] pc_i = 24'd0;
    logic [23:0] instr_i = 24'd0;
    logic [23:0] res_i = 24'd0;
    logic [3:0]  gp_i = 4'd0;
    logic        arm_i = 1'b0;
    logic [23:0] trig_i = 24'd0;
    logic        ready_i = 1'b0;
    logic [1:0]  ow_state;
    logic [4:0]  ow_count;
    logic        ow_rd_valid;
    logic [23:0] ow_rd_pc;
    logic [23:0] ow_rd_instr;
    logic [23:0] ow_rd_result;
    logic [3:0]  ow_rd_tgt_gp;
`ifdef TRACE_TS_EN
    logic [31:0] ow_rd_ts;
`endif

    wb_trace_buf #(
        .PC_W(24), .INSTR_W(24), .DATA_W(24), .DEPTH(DEPTH), .POST_CNT(POST_CNT)
    ) dut (
        .iw_clk       (clk),
        .iw_rst       (rst_n),
        .iw_wb_valid  (valid_i),
        .iw_wb_pc     (pc_i),
        .iw_wb_instr  (instr_i),
        .iw_wb_result (res_i),
        .iw_wb_tgt_gp (gp_i),
        .iw_arm       (arm_i),
        .iw_trig_pc   (trig_i),
        .iw_rd_ready  (ready_i),
        .ow_state     (ow_state),
        .ow_count     (ow_count),
        .ow_rd_valid  (ow_rd_valid),
        .ow_rd_pc     (ow_rd_pc),
        .ow_rd_instr  (ow_rd_instr),
        .ow_rd_result (ow_rd_result),
        .ow_rd_tgt_gp (ow_rd_tgt_gp)
`ifdef TRACE_TS_EN
        ,
        .ow_rd_ts     (ow_rd_ts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] pc;
        logic [23:0] instr;
        logic [23:0] res;
        logic [3:0]  gp;
        logic [31:0] ts;
    } ent_t;

    typedef struct {
        logic        arm;
        logic        valid;
        logic [23:0] pc;
        logic        ready;
        logic [1:0]  e_state;
        logic [4:0]  e_count;
        logic        e_valid;
        logic [23:0] e_pc;
    } vec_t;

    // Reference model: the trace is a queue of entries, oldest at the front.
    ent_t        mq[$];
    int          mst  = 0;
    int          mpost = 0;
    logic [31:0] mts  = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mst   = 0;
        mpost = 0;
        mts   = 32'd0;
    endtask

    task automatic model_edge();
        ent_t e;
        e.pc = pc_i; e.instr = instr_i; e.res = res_i; e.gp = gp_i; e.ts = mts;
        if (arm_i) begin
            mq.delete();
            mst   = 1;
            mpost = 0;
        end else if ((mst == 1 || mst == 2) && valid_i) begin
            mq.push_back(e);
            if (mq.size() > DEPTH) mq.delete(0);
            if (mst == 1 && pc_i == trig_i) begin
                mpost = 1;
                mst   = (POST_CNT == 1) ? 3 : 2;
            end else if (mst == 2) begin
                mpost++;
                if (mpost == POST_CNT) mst = 3;
            end
        end else if (mst == 3 && mq.size() > 0 && ready_i) begin
            mq.delete(0);
        end
        mts = mts + 32'd1;
    endtask

    task automatic model_check(input string tag);
        bit v;
        v = (mst == 3) && (mq.size() > 0);
        chk({tag, ".state"}, ow_state, mst);
        chk({tag, ".count"}, ow_count, mq.size());
        chk({tag, ".rd_valid"}, ow_rd_valid, v);
        if (v) begin
            chk({tag, ".rd_pc"}, ow_rd_pc, mq[0].pc);
            chk({tag, ".rd_instr"}, ow_rd_instr, mq[0].instr);
            chk({tag, ".rd_result"}, ow_rd_result, mq[0].res);
            chk({tag, ".rd_gp"}, ow_rd_tgt_gp, mq[0].gp);
`ifdef TRACE_TS_EN
            chk({tag, ".rd_ts"}, ow_rd_ts, mq[0].ts);
`endif
        end
    endtask

    // One clock: drive at the falling edge, advance the model at the rising edge, check at the next falling edge.
    task automatic step(input logic arm, input logic valid, input logic [23:0] pc,
                        input logic ready, input string tag);
        arm_i   = arm;
        valid_i = valid;
        pc_i    = pc;
        instr_i = pc ^ 24'h5a5a5a;
        res_i   = 24'($urandom);
        gp_i    = 4'($urandom);
        ready_i = ready;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        arm_i   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        model_check(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic vec_t mk(input logic arm, input logic valid, input logic [23:0] pc,
                                input logic ready, input logic [1:0] es, input logic [4:0] ec,
                                input logic ev, input logic [23:0] ep);
        vec_t v;
        v.arm = arm; v.valid = valid; v.pc = pc; v.ready = ready;
        v.e_state = es; v.e_count = ec; v.e_valid = ev; v.e_pc = ep;
        return v;
    endfunction

    vec_t tv[18];
    logic pat[4];

    initial begin
        int          exp_pc;
        logic [31:0] prev_ts;

        // Reset values, sampled while reset is still asserted.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.state", ow_state, 2'd0);
        chk("rst.count", ow_count, 5'd0);
        chk("rst.rd_valid", ow_rd_valid, 1'b0);
        chk("rst.rd_pc", ow_rd_pc, 24'd0);
        rst_n = 1'b1;
        model_reset();

        // Trigger on the first retire after arm: pcs 5..12, then drain 8 entries.
        tv[0] = mk(1'b1, 1'b0, 24'd0, 1'b0, 2'd1, 5'd0, 1'b0, 24'd0);
        for (int k = 1; k <= 8; k++)
            tv[k] = mk(1'b0, 1'b1, 24'(4 + k), 1'b0, (k < 8) ? 2'd2 : 2'd3, 5'(k),
                       (k == 8), 24'd5);
        for (int j = 1; j <= 9; j++)
            tv[8 + j] = mk(1'b0, 1'b0, 24'd0, 1'b1, 2'd3, (j <= 8) ? 5'(8 - j) : 5'd0,
                           (j < 8), 24'(5 + j));
        trig_i = 24'd5;
        for (int i = 0; i < 18; i++) begin
            step(tv[i].arm, tv[i].valid, tv[i].pc, tv[i].ready, "tv");
            chk("tv.state", ow_state, tv[i].e_state);
            chk("tv.count", ow_count, tv[i].e_count);
            chk("tv.rd_valid", ow_rd_valid, tv[i].e_valid);
            if (tv[i].e_valid) chk("tv.rd_pc", ow_rd_pc, tv[i].e_pc);
        end

        // Ring wrap: pcs 0..29, trigger at 20, keep 20..27, oldest surviving is 12.
        trig_i = 24'd20;
        step(1'b1, 1'b0, 24'd0, 1'b0, "t2");
        for (int p = 0; p < 30; p++) step(1'b0, 1'b1, 24'(p), 1'b0, "t2");
        chk("t2.state", ow_state, 2'd3);
        chk("t2.count", ow_count, 5'd16);
        for (int i = 0; i < 16; i++) begin
            chk("t2.rd_valid", ow_rd_valid, 1'b1);
            chk("t2.rd_pc", ow_rd_pc, 24'(12 + i));
            step(1'b0, 1'b0, 24'd0, 1'b1, "t2");
        end
        chk("t2.rd_valid_end", ow_rd_valid, 1'b0);

        // Drain with ready toggling 1,0,0,1: data holds while stalled, nothing skipped or duplicated.
        trig_i = 24'd100;
        step(1'b1, 1'b0, 24'd0, 1'b0, "t4");
        for (int p = 100; p < 108; p++) step(1'b0, 1'b1, 24'(p), 1'b0, "t4");
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        exp_pc = 100;
        for (int c = 0; c < 40 && ow_rd_valid; c++) begin
            chk("t4.rd_pc", ow_rd_pc, 24'(exp_pc));
            step(1'b0, 1'b0, 24'd0, pat[c % 4], "t4");
            if (pat[c % 4]) exp_pc++;
        end
        chk("t4.total_read", exp_pc, 108);

        // Arm in DONE with count=3 and a same-cycle read: arm wins.
        trig_i = 24'd200;
        step(1'b1, 1'b0, 24'd0, 1'b0, "t5");
        for (int p = 200; p < 208; p++) step(1'b0, 1'b1, 24'(p), 1'b0, "t5");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 24'd0, 1'b1, "t5");
        chk("t5.count_before", ow_count, 5'd3);
        step(1'b1, 1'b0, 24'd0, 1'b1, "t5");
        chk("t5.state", ow_state, 2'd1);
        chk("t5.count", ow_count, 5'd0);
        chk("t5.rd_valid", ow_rd_valid, 1'b0);
        step(1'b0, 1'b1, 24'd210, 1'b0, "t5");
        chk("t5.recapture", ow_count, 5'd1);

        // Reset during POST discards everything; IDLE neither captures nor reads.
        trig_i = 24'd300;
        step(1'b1, 1'b0, 24'd0, 1'b0, "t1");
        for (int p = 300; p < 303; p++) step(1'b0, 1'b1, 24'(p), 1'b0, "t1");
        chk("t1.in_post", ow_state, 2'd2);
        do_reset();
        chk("t1.state", ow_state, 2'd0);
        chk("t1.count", ow_count, 5'd0);
        chk("t1.rd_valid", ow_rd_valid, 1'b0);
        chk("t1.rd_pc", ow_rd_pc, 24'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 24'd300, 1'b1, "t1");
        chk("t1.idle_count", ow_count, 5'd0);

        // Random traffic against the reference model.
        for (int r = 0; r < 20; r++) begin
            trig_i = 24'($urandom_range(0, 31));
            step(1'b1, 1'b0, 24'd0, 1'b0, "rnd");
            for (int c = 0; c < 80; c++)
                step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                     24'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), "rnd");
        end

`ifdef TRACE_TS_EN
        // Retires three cycles apart must carry timestamps exactly three apart.
        trig_i = 24'd400;
        step(1'b1, 1'b0, 24'd0, 1'b0, "t6");
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b1, 24'(400 + k), 1'b0, "t6");
            step(1'b0, 1'b0, 24'd0, 1'b0, "t6");
            step(1'b0, 1'b0, 24'd0, 1'b0, "t6");
        end
        prev_ts = 32'd0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) chk("t6.ts_delta", ow_rd_ts - prev_ts, 32'd3);
            prev_ts = ow_rd_ts;
            step(1'b0, 1'b0, 24'd0, 1'b1, "t6");
        end
`else
        prev_ts = 32'd0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
